// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: the W-stage source (A) has fixed priority, and late results (B) queue in a kill-tagged FIFO.
// The block also provides scoreboard lookups for D-stage readers and a starvation stall so queued B writes always drain.
module grf_wb_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [4:0]               a_addr,
  input  logic [31:0]              a_data,
  input  logic [31:0]              a_pc,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_addr,
  input  logic [31:0]              b_data,
  input  logic [31:0]              b_pc,
  input  logic [4:0]               rs_addr,
  input  logic [4:0]               rt_addr,
  output logic                     busy_rs,
  output logic                     busy_rt,
  output logic                     stall_req,
  output logic                     grf_we,
  output logic [4:0]               grf_waddr,
  output logic [31:0]              grf_wdata,
  output logic [31:0]              grf_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [DEPTH-1:0] kill_q, kill_d;
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             push, pop, a_kill, nonempty;

  // The FIFO is treated as empty while reset is high, so no queued write leaks out during a flush.
  assign nonempty   = (count_q != '0) && !reset;
  assign b_ready    = (count_q < CW'(DEPTH));
  assign push       = b_valid && b_ready && (b_addr != '0);
  assign pop        = nonempty && !a_valid;
  assign a_kill     = a_valid && (a_addr != '0);
  assign stall_req  = (starve_q == SW'(STARVE_LIMIT));
  assign fifo_count = count_q;

  always_comb begin
    grf_we    = 1'b0;
    grf_waddr = '0;
    grf_wdata = '0;
    grf_pc    = '0;
    if (a_valid) begin
      grf_we    = (a_addr != '0);
      grf_waddr = a_addr;
      grf_wdata = a_data;
      grf_pc    = a_pc;
    end else if (nonempty) begin
      grf_we    = !kill_q[rd_q];
      grf_waddr = addr_q[rd_q];
      grf_wdata = data_q[rd_q];
      grf_pc    = pc_q[rd_q];
    end
  end

  always_comb begin
    wr_d     = wr_q;
    rd_d     = rd_q;
    kill_d   = kill_q;
    starve_d = starve_q;
    // Kill every matching slot; a stale bit on a free slot is harmless because push rewrites it.
    if (a_kill) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == a_addr) kill_d[i] = 1'b1;
      end
    end
    if (push) begin
      kill_d[wr_q] = a_kill && (b_addr == a_addr);
      wr_d         = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    if (pop || (count_q == '0)) begin
      starve_d = '0;
    end else if (a_valid && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_comb begin
    logic [PW-1:0] offset;
    offset  = '0;
    busy_rs = 1'b0;
    busy_rt = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_q;
      if ((CW'(offset) < count_q) && !kill_q[i]) begin
        if (addr_q[i] == rs_addr) busy_rs = 1'b1;
        if (addr_q[i] == rt_addr) busy_rt = 1'b1;
      end
    end
    if (rs_addr == '0) busy_rs = 1'b0;
    if (rt_addr == '0) busy_rt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      kill_q   <= '0;
      starve_q <= '0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      kill_q   <= kill_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_q] <= b_addr;
      data_q[wr_q] <= b_data;
      pc_q[wr_q]   <= b_pc;
    end
  end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
Shares the single GRF write port between two requesters. Source A is the in-order W-stage writeback; it has fixed priority and is never blocked. Source B is a long-latency unit (MDU/late-load); it is decoupled through a DEPTH-entry FIFO. The block provides scoreboard lookups so the hazard unit stalls readers of pending registers, and a starvation stall request so B always drains. It sits between the W stage, the late-result unit and D_GRF's write port.

Parameters:
DEPTH, 4, FIFO entries for B writes; power of two, >=2
STARVE_LIMIT, 8, cycles a valid FIFO head may wait before stall_req asserts; >=1

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high; clears all state
a_valid  in  1  W-stage write request
a_addr  in  5  W-stage destination register
a_data  in  32  W-stage write data
a_pc  in  32  W-stage instruction PC
b_valid  in  1  late-unit write request
b_ready  out  1  FIFO can accept B this cycle
b_addr  in  5  late-unit destination
b_data  in  32  late-unit data
b_pc  in  32  late-unit instruction PC
rs_addr  in  5  scoreboard query 1 (D stage)
rt_addr  in  5  scoreboard query 2 (D stage)
busy_rs  out  1  a live FIFO entry targets rs_addr (rs_addr!=0)
busy_rt  out  1  same for rt_addr
stall_req  out  1  starvation: pipeline must insert a W bubble
grf_we  out  1  to D_GRF regWriteEn
grf_waddr  out  5  to D_GRF regWriteAddr
grf_wdata  out  32  to D_GRF regWriteData
grf_pc  out  32  to D_GRF PC
fifo_count  out  $clog2(DEPTH)+1  live+killed entries held

Behaviour:
- Reset (sync): FIFO empty, all kill bits 0, starve counter 0. Outputs then: grf_we=0, grf_waddr=0, grf_wdata=0, grf_pc=0, b_ready=1, busy_*=0, stall_req=0, fifo_count=0.
- B accept: handshake b_valid&&b_ready at posedge. b_ready = (fifo_count<DEPTH), registered-state only, not dependent on this cycle's pop. b_addr==0 is accepted and discarded (no push).
- Accepted entry is writable no earlier than the next cycle (min latency 1); B never bypasses to the port in its accept cycle.
- Port mux (combinational):
  - a_valid=1: drive A fields. grf_we = (a_addr!=0).
  - else, FIFO non-empty: drive head fields and pop at posedge. grf_we = !head.kill.
  - else: grf_we=0; addr/data/pc driven 0.
- Ordering: A is always the younger write. When a_valid && a_addr!=0, every FIFO entry with addr==a_addr gets kill=1 at that posedge, including one pushed the same cycle. A killed head pops without writing (grf_we=0), consuming its cycle.
- Scoreboard: busy_rs = OR over occupied, non-killed entries of (addr==rs_addr), forced 0 when rs_addr==0; busy_rt likewise. Combinational from registered state. An entry accepted this cycle is visible next cycle.
- Starvation: counter increments each cycle FIFO non-empty && a_valid, and saturates at STARVE_LIMIT. It clears on any pop or when empty. stall_req = (counter==STARVE_LIMIT). A keeps priority even while stall_req=1; stall_req falls the cycle after the head pops.
- Simultaneous push+pop: count unchanged; pointers wrap mod DEPTH.
- Full: b_ready=0 and B holds its request; no overflow. Empty: no pop, no write from FIFO.
- Reset mid-operation discards all FIFO contents, including unwritten entries (pipeline is flushed too).

Test Plan:
- Reset, then a_valid with a_addr=5, a_data=0x1234: grf_we=1, waddr=5, wdata=0x1234 same cycle; a_addr=0 gives grf_we=0.
- B pushes addr 8 (data 0xAAAA) with A idle: next cycle busy for rs_addr=8 is 1, grf_we=1, waddr=8; the cycle after, busy=0 and fifo_count=0.
- Push 4 B entries (DEPTH=4) while a_valid held high: b_ready=0 after the 4th, fifo_count=4. stall_req rises after 8 A cycles. Drop a_valid: entries drain in order, one per cycle.
- B pushes addr 9 (0x1111), then A writes 9 (0x2222) before drain: entry is killed, busy_rs(9)=0, and the drain cycle has grf_we=0. GRF ends with 0x2222.
- Full FIFO with simultaneous pop and b_valid: no push that cycle (b_ready=0); push accepted the next cycle; count never exceeds 4.
- Assert reset with 3 entries queued: next cycle fifo_count=0, busy=0, stall_req=0, and no queued write reaches the GRF.
